// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a registered result and persistent carry/sign/zero/overflow flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode C); otherwise C is a NOP.
//
// state  | meaning
// IDLE   | ready; single-cycle ops complete here, MUL accept moves to MUL
// MUL    | one shift-add step per cycle, LSB of B first; in_ready low
// DONE   | product and flags visible with out_valid; ready, accepts like IDLE
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opco,
  input  logic [WIDTH-1:0] O1,
  input  logic [WIDTH-1:0] O2,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_hi,
  output logic             carry,
  output logic             sign,
  output logic             zero,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_XNOR = 4'h6;
  localparam logic [3:0] OP_PASS = 4'h7;
  localparam logic [3:0] OP_ADC  = 4'h8;
  localparam logic [3:0] OP_SBB  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;

  if (WIDTH < 4 || WIDTH > 32 || (2 ** CNT_W) <= WIDTH) begin : g_param_check
    $error("alu_seq: WIDTH must be 4..32 and 2**CNT_W must exceed WIDTH");
  end

  logic             accept;
  logic             is_mul;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_upd;

  assign accept = in_valid && in_ready;

  // Carry-in only feeds the chained ops; the flag doubles as borrow for SBB.
  always_comb begin
    cin       = (opco == OP_ADC || opco == OP_SBB) ? carry : 1'b0;
    sum       = {1'b0, O1} + {1'b0, O2} + {{WIDTH{1'b0}}, cin};
    dif       = {1'b0, O1} - {1'b0, O2} - {{WIDTH{1'b0}}, cin};
    alu_res   = Result;
    alu_carry = carry;
    alu_ovf   = ovf;
    alu_upd   = 1'b1;
    case (opco)
      OP_ADD, OP_ADC: begin
        alu_res   = sum[MSB:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (O1[MSB] == O2[MSB]) && (sum[MSB] != O1[MSB]);
      end
      OP_SUB, OP_SBB: begin
        alu_res   = dif[MSB:0];
        alu_carry = dif[WIDTH];
        alu_ovf   = (O1[MSB] != O2[MSB]) && (dif[MSB] != O1[MSB]);
      end
      OP_AND:  begin alu_res = O1 & O2;    alu_carry = 1'b0; alu_ovf = 1'b0; end
      OP_OR:   begin alu_res = O1 | O2;    alu_carry = 1'b0; alu_ovf = 1'b0; end
      OP_XOR:  begin alu_res = O1 ^ O2;    alu_carry = 1'b0; alu_ovf = 1'b0; end
      OP_XNOR: begin alu_res = ~(O1 ^ O2); alu_carry = 1'b0; alu_ovf = 1'b0; end
      OP_PASS: begin alu_res = O2;         alu_carry = 1'b0; alu_ovf = 1'b0; end
      OP_SHL: begin
        alu_res   = O1 << 1;
        alu_carry = O1[MSB];
        alu_ovf   = 1'b0;
      end
      OP_SHR: begin
        alu_res   = O1 >> 1;
        alu_carry = O1[0];
        alu_ovf   = 1'b0;
      end
      default: alu_upd = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic               mul_last;

  assign in_ready = (state != S_MUL);
  assign is_mul   = (opco == OP_MUL);
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign mul_last = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else begin
      case (state)
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (mul_last) state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          if (accept && is_mul) begin
            state  <= S_MUL;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, O1};
            mplier <= O2;
            prod   <= '0;
          end
        end
      endcase
    end
  end
`else
  assign in_ready = 1'b1;
  assign is_mul   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Result_hi <= '0;
      carry     <= 1'b0;
      sign      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= accept && !is_mul;
      if (accept && !is_mul && alu_upd) begin
        Result    <= alu_res;
        Result_hi <= '0;
        carry     <= alu_carry;
        sign      <= alu_res[MSB];
        zero      <= (alu_res == '0);
        ovf       <= alu_ovf;
      end
`ifdef ALU_SEQ_MUL_EN
      // The last shift-add step writes the product so it is visible during DONE.
      if (mul_last) begin
        out_valid <= 1'b1;
        Result    <= prod_nxt[MSB:0];
        Result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
        carry     <= |prod_nxt[2*WIDTH-1:WIDTH];
        sign      <= prod_nxt[MSB];
        zero      <= (prod_nxt == '0);
        ovf       <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed literal checks plus randomized ops against a behavioural model.
// Follows ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;
  localparam int W = 8;
  localparam longint MASK = (longint'(1) << W) - 1;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opco = 4'h0;
  logic [W-1:0] O1 = '0;
  logic [W-1:0] O2 = '0;
  logic         out_valid;
  logic [W-1:0] Result;
  logic [W-1:0] Result_hi;
  logic         carry, sign, zero, ovf;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opco(opco), .O1(O1), .O2(O2), .out_valid(out_valid),
    .Result(Result), .Result_hi(Result_hi),
    .carry(carry), .sign(sign), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural reference: plain integer arithmetic, a busy countdown for MUL.
  logic [W-1:0] m_res = '0, m_hi = '0;
  logic         m_c = 1'b0, m_s = 1'b0, m_z = 1'b0, m_v = 1'b0;
  logic         m_ov = 1'b0, m_ready = 1'b1;
  int           m_busy = 0;
  longint       m_prod = 0;

  function automatic longint sx(input longint v);
    return (v > SMAX) ? v - (MASK + 1) : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    longint a, b, t, st, ci;
    bit     upd;
    if (!rst_n) begin
      m_res = '0; m_hi = '0; m_c = 0; m_s = 0; m_z = 0; m_v = 0;
      m_ov = 0; m_ready = 1; m_busy = 0;
    end else begin
      m_ov = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_res = W'(m_prod & MASK);
          m_hi  = W'((m_prod >> W) & MASK);
          m_c   = (m_hi != 0);
          m_z   = (m_prod == 0);
          m_s   = ((m_prod >> (W - 1)) & 1) != 0;
          m_v   = 0;
          m_ov  = 1;
        end
      end else if (in_valid) begin
        a = longint'(O1); b = longint'(O2);
        ci = (opco == 4'h8 || opco == 4'h9) ? longint'(m_c) : 0;
        m_ov = 1; upd = 1; t = 0;
        case (opco)
          4'h1, 4'h8: begin
            t = a + b + ci; st = sx(a) + sx(b) + ci;
            m_c = (t > MASK); m_v = (st > SMAX) || (st < SMIN);
          end
          4'h2, 4'h9: begin
            t = a - b - ci; st = sx(a) - sx(b) - ci;
            m_c = (t < 0); m_v = (st > SMAX) || (st < SMIN);
          end
          4'h3: begin t = a & b; m_c = 0; m_v = 0; end
          4'h4: begin t = a | b; m_c = 0; m_v = 0; end
          4'h5: begin t = a ^ b; m_c = 0; m_v = 0; end
          4'h6: begin t = ~(a ^ b); m_c = 0; m_v = 0; end
          4'h7: begin t = b; m_c = 0; m_v = 0; end
          4'hA: begin t = a * 2; m_c = (a > SMAX); m_v = 0; end
          4'hB: begin t = a / 2; m_c = (a % 2) != 0; m_v = 0; end
`ifdef ALU_SEQ_MUL_EN
          4'hC: begin m_busy = W; m_prod = a * b; m_ov = 0; upd = 0; end
`endif
          default: upd = 0;
        endcase
        if (upd) begin
          m_res = W'(t & MASK);
          m_hi  = '0;
          m_s   = ((t & MASK) > SMAX);
          m_z   = ((t & MASK) == 0);
        end
      end
      m_ready = (m_busy == 0);
    end
  end

  // Every cycle out of reset, all outputs must equal the model.
  always @(negedge clk) begin
    if (rst_n && cmp_en)
      chk("cycle", {out_valid, in_ready, Result, Result_hi, carry, sign, zero, ovf},
                   {m_ov, m_ready, m_res, m_hi, m_c, m_s, m_z, m_v});
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    in_valid = 1; opco = op; O1 = a; O2 = b;
    for (int k = 0; k < 64 && !ok; k++) begin
      ok = m_ready;
      @(posedge clk); #1;
      if (!ok) @(negedge clk);
    end
    in_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic expect_op(input string nm, input logic [W-1:0] r, input logic c, input logic s,
                           input logic z, input logic v);
    chk({nm, "_dut"},   {out_valid, Result, carry, sign, zero, ovf}, {1'b1, r, c, s, z, v});
    chk({nm, "_model"}, {m_ov, m_res, m_c, m_s, m_z, m_v},         {1'b1, r, c, s, z, v});
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(MASK);
      2: return W'(SMAX);
      3: return W'(SMAX + 1);
      default: return W'($urandom);
    endcase
  endfunction

`ifdef ALU_SEQ_MUL_EN
  task automatic run_mul_latency(output int lat, output int busy);
    lat = 1; busy = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, in_ready, Result, Result_hi, carry, sign, zero, ovf},
                         {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}, 4'b0000});
    rst_n = 1;
    @(negedge clk);
    cmp_en = 1;

    send(4'h1, 8'hFF, 8'h01); expect_op("add_ff_01", 8'h00, 1, 0, 1, 0);
    send(4'h8, 8'h01, 8'h01); expect_op("adc_c1",    8'h03, 0, 0, 0, 0);
    send(4'h1, 8'h7F, 8'h01); expect_op("add_7f_01", 8'h80, 0, 1, 0, 1);
    send(4'h8, 8'h01, 8'h01); expect_op("adc_c0",    8'h02, 0, 0, 0, 0);
    send(4'h2, 8'h10, 8'h20); expect_op("sub_10_20", 8'hF0, 1, 1, 0, 0);
    send(4'h5, 8'hAA, 8'hAA); expect_op("xor_b2b",   8'h00, 0, 0, 1, 0);
    send(4'h2, 8'h10, 8'h20);
`ifndef ALU_SEQ_MUL_EN
    send(4'hC, 8'h03, 8'h04); expect_op("op_c_nop", 8'hF0, 1, 1, 0, 0);
    chk("op_c_hi", Result_hi, 0);
`endif
    send(4'hE, 8'h03, 8'h04); expect_op("op_e_nop", 8'hF0, 1, 1, 0, 0);
    send(4'hA, 8'h81, 8'h00); expect_op("shl_81",   8'h02, 1, 0, 0, 0);
    send(4'hB, 8'h81, 8'h00); expect_op("shr_81",   8'h40, 1, 0, 0, 0);

`ifdef ALU_SEQ_MUL_EN
    begin
      int lat, busy;
      send(4'hC, 8'h0F, 8'h11);
      in_valid = 1; opco = 4'h1; O1 = 8'h01; O2 = 8'h02;
      run_mul_latency(lat, busy);
      chk("mul_latency", lat, W + 1);
      chk("mul_busy_cycles", busy, W);
      expect_op("mul_0f_11", 8'hFF, 0, 1, 0, 0);
      chk("mul_0f_11_hi", Result_hi, 8'h00);
      chk("ready_in_done", in_ready, 1);
      @(posedge clk); #1 in_valid = 0;
      @(negedge clk);
      expect_op("add_after_mul", 8'h03, 0, 0, 0, 0);

      send(4'hC, 8'hFF, 8'hFF);
      run_mul_latency(lat, busy);
      expect_op("mul_ff_ff", 8'h01, 1, 0, 0, 0);
      chk("mul_ff_ff_hi", {Result_hi, m_hi}, {8'hFE, 8'hFE});
      @(negedge clk);

      send(4'hC, 8'hFF, 8'hFF);
      repeat (3) @(negedge clk);
      rst_n = 0; #1;
      chk("reset_mid_mul", {out_valid, in_ready, Result, Result_hi, carry, sign, zero, ovf},
                           {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}, 4'b0000});
      @(negedge clk); rst_n = 1;
      busy = 0;
      repeat (12) begin @(negedge clk); if (out_valid) busy++; end
      chk("no_valid_after_reset", busy, 0);
    end
`endif

    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
    end
    repeat (W + 3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
